alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Sequential front-end for the 20-bit ALU datapath. Accepts one operation request (4-bit opcode, two 20-bit operands, carry-in) over a valid/ready handshake.
- Executes the operation in one cycle, or iteratively for multiply and variable rotate. Returns a registered result with carry and zero flags over a second valid/ready handshake.
- Sits between the instruction controller and the word-level ALU components. It is the issuing and collecting end of the 4-bit operation-select interface.

Parameters:
- WIDTH, 20, operand/result width in bits.
- OPW, 4, opcode width; 16 opcodes.
- SHW, 4, shift/rotate amount width; amount taken from req_b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_op  input  4  opcode.
- req_a  input  20  operand A.
- req_b  input  20  operand B / shift amount.
- req_cin  input  1  carry-in, used by ADD only.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_result  output  20  result word.
- rsp_cout  output  1  carry/borrow/overflow flag.
- rsp_zero  output  1  rsp_result == 0 (CMP: operands equal).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, busy=0, all internal counters/accumulators 0.
- Reset during EXEC or DONE aborts the operation; no response is produced.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge T, capture op/a/b/cin. Single-cycle ops go to DONE at T+1. MUL goes to EXEC. ROLN goes to EXEC if amount≠0, else DONE.
  - EXEC: one iteration per cycle. MUL runs exactly 20 cycles (T+1..T+20), DONE at T+21. ROLN runs n=b[3:0] cycles, DONE at T+1+n.
  - DONE: rsp_valid=1. rsp_result, rsp_cout and rsp_zero are held stable until rsp_valid&&rsp_ready. On that handshake go to IDLE, with rsp_valid=0 next cycle.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after the response handshake. req_valid outside IDLE is ignored; the requester holds it.
- Operands are captured at acceptance; changes on req_* after acceptance have no effect.
- Opcodes; cout=0 unless stated; all arithmetic is modulo 2^20:
  - 0 PASSA: a.
  - 1 PASSB: b.
  - 2 NOT: ~a.
  - 3 AND: a&b.
  - 4 OR: a|b.
  - 5 XOR: a^b.
  - 6 ADD: {cout,res} = a+b+cin, 21-bit.
  - 7 SUB: a-b; cout = borrow, i.e. 1 iff a<b unsigned.
  - 8 INC: a+1; cout=1 iff a==0xFFFFF.
  - 9 SHL: a<<b[3:0].
  - 10 SHR: a>>b[3:0], logical.
  - 11 ROL1: {a[18:0],a[19]}.
  - 12 ROR1: {a[0],a[19:1]}.
  - 13 MUL: shift-add, one multiplier bit per EXEC cycle using a 40-bit product. Result = product[19:0]; cout = |product[39:20].
  - 14 ROLN: rotate left by b[3:0], one bit per EXEC cycle.
  - 15 CMP: result=0; zero = (a==b); cout = (a<b) unsigned.
- rsp_zero = (rsp_result==0) for every op except CMP.
- busy=1 in EXEC and DONE.

Test Plan:
- ADD a=0xFFFFF, b=0x00001, cin=0, accepted at T -> rsp_valid at T+1, result 0x00000, cout=1, zero=1.
- SUB a=0x00005, b=0x00007 -> result 0xFFFFE, cout=1, zero=0, latency 1.
- MUL a=0x00003, b=0x00005 -> result 0x0000F, cout=0, rsp_valid first high at T+21. MUL a=0x80000, b=0x00002 -> result 0x00000, cout=1, zero=1.
- ROLN a=0x80001, b=0x00004 -> result 0x00018 at T+5. ROLN with b=0x00010 (amount 0) -> result 0x80001 at T+1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result/flags stable, req_ready=0, a new req_valid is not accepted. rsp_ready=1 -> IDLE and req_ready=1 the next cycle.
- rst=1 at T+10 during MUL -> next cycle state IDLE, rsp_valid=0, all outputs 0. A following ADD 0x00002+0x00003 -> 0x00005 normally.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential front-end for the word-level ALU datapath.
// It accepts one operation over a req valid/ready handshake. The operation
// finishes in one cycle, or over several cycles for MUL and ROLN. The unit
// returns a registered result with carry and zero flags over a rsp
// valid/ready handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op, req_a, req_b  opcode and operands (req_b[SHW-1:0] = shift amount)
//   req_cin               carry-in, used by ADD only
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            result word
//   rsp_cout, rsp_zero    carry/borrow/overflow flag, result-is-zero flag
//   busy                  high while executing or holding a response
module alu_seq_unit #(
  parameter int WIDTH = 20,
  parameter int OPW   = 4,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [OPW-1:0] {
    OP_PASSA, OP_PASSB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
    OP_INC, OP_SHL, OP_SHR, OP_ROL1, OP_ROR1, OP_MUL, OP_ROLN, OP_CMP
  } op_t;

  state_t             state, state_nxt;
  logic [OPW-1:0]     op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     add_sum, sub_diff, inc_sum;
  logic [WIDTH-1:0]   res_c;
  logic               cout_c, zero_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rol_next;
  logic               last;

  // Single-cycle results, computed directly from the request at acceptance.
  always_comb begin
    amt      = req_b[SHW-1:0];
    add_sum  = {1'b0, req_a} + {1'b0, req_b} + {{WIDTH{1'b0}}, req_cin};
    sub_diff = {1'b0, req_a} - {1'b0, req_b};
    inc_sum  = {1'b0, req_a} + (WIDTH+1)'(1);
    res_c    = '0;
    cout_c   = 1'b0;
    case (op_t'(req_op))
      OP_PASSA: res_c = req_a;
      OP_PASSB: res_c = req_b;
      OP_NOT:   res_c = ~req_a;
      OP_AND:   res_c = req_a & req_b;
      OP_OR:    res_c = req_a | req_b;
      OP_XOR:   res_c = req_a ^ req_b;
      OP_ADD:   {cout_c, res_c} = add_sum;
      OP_SUB:   {cout_c, res_c} = sub_diff;
      OP_INC:   {cout_c, res_c} = inc_sum;
      OP_SHL:   res_c = req_a << amt;
      OP_SHR:   res_c = req_a >> amt;
      OP_ROL1:  res_c = {req_a[WIDTH-2:0], req_a[WIDTH-1]};
      OP_ROR1:  res_c = {req_a[0], req_a[WIDTH-1:1]};
      // Only reached here with a zero amount; nonzero amounts iterate.
      OP_ROLN:  res_c = req_a;
      OP_CMP:   cout_c = (req_a < req_b);
      default:  res_c = '0;
    endcase
    zero_c = (op_t'(req_op) == OP_CMP) ? (req_a == req_b) : (res_c == '0);
  end

  // Iteration step. MUL keeps the multiplier in acc's low half: add A to
  // the high half when the current multiplier bit is set, then shift the
  // product right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rol_next = {a_reg[WIDTH-2:0], a_reg[WIDTH-1]};
    last     = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (op_t'(req_op) == OP_MUL ||
              (op_t'(req_op) == OP_ROLN && amt != '0))
            state_nxt = EXEC;
          else
            state_nxt = DONE;
        end
      end
      EXEC: if (last) state_nxt = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      a_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_reg <= req_op;
          a_reg  <= req_a;
          if (op_t'(req_op) == OP_MUL) begin
            acc <= {{WIDTH{1'b0}}, req_b};
            cnt <= CW'(WIDTH);
          end else if (op_t'(req_op) == OP_ROLN && amt != '0) begin
            cnt <= CW'(amt);
          end else begin
            rsp_result <= res_c;
            rsp_cout   <= cout_c;
            rsp_zero   <= zero_c;
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (op_t'(op_reg) == OP_MUL) begin
            acc <= mul_next;
            if (last) begin
              rsp_result <= mul_next[WIDTH-1:0];
              rsp_cout   <= |mul_next[2*WIDTH-1:WIDTH];
              rsp_zero   <= (mul_next[WIDTH-1:0] == '0);
            end
          end else begin
            a_reg <= rol_next;
            if (last) begin
              rsp_result <= rol_next;
              rsp_cout   <= 1'b0;
              rsp_zero   <= (rol_next == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with an arithmetic reference model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic        req_cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [19:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [19:0] exp_res;
  logic        exp_cout, exp_zero;
  bit          chk_en = 0;

  alu_seq_unit #(.WIDTH(20), .OPW(4), .SHW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {cout, zero, result[19:0]}.
  function automatic logic [21:0] model(input int op, input logic [19:0] a,
                                        input logic [19:0] b, input logic cin);
    longint unsigned A, B, M, r, p;
    int n;
    logic co, z;
    A = a; B = b; M = 64'hFFFFF; n = b[3:0]; co = 1'b0; r = 0;
    case (op)
      0:  r = A;
      1:  r = B;
      2:  r = ~A & M;
      3:  r = A & B;
      4:  r = A | B;
      5:  r = A ^ B;
      6:  begin p = A + B + cin; r = p & M; co = (p > M); end
      7:  begin r = (A - B) & M; co = (A < B); end
      8:  begin r = (A + 1) & M; co = (A == M); end
      9:  r = (A << n) & M;
      10: r = A >> n;
      11: r = ((A << 1) | (A >> 19)) & M;
      12: r = ((A >> 1) | (A << 19)) & M;
      13: begin p = A * B; r = p & M; co = ((p >> 20) != 0); end
      14: r = ((A << n) | (A >> (20 - n))) & M;
      default: begin r = 0; co = (A < B); end
    endcase
    z = (op == 15) ? (A == B) : (r == 0);
    return {co, z, r[19:0]};
  endfunction

  // Compares the held response against the model on every cycle it is valid.
  always @(negedge clk) begin
    if (chk_en && rsp_valid) begin
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_cout", rsp_cout, exp_cout);
      chk("rsp_zero", rsp_zero, exp_zero);
      chk("busy_in_done", busy, 1);
    end
  end

  task automatic accept(input int op, input logic [19:0] a, input logic [19:0] b,
                        input logic cin, output bit ok);
    logic [21:0] e;
    e = model(op, a, b, cin);
    @(negedge clk);
    exp_cout = e[21]; exp_zero = e[20]; exp_res = e[19:0];
    req_op = op[3:0]; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: captured operands must be used.
    req_valid = 1'b0; req_a = ~a; req_b = b ^ 20'h5A5A5; req_cin = ~cin;
  endtask

  task automatic run_op(input int op, input logic [19:0] a, input logic [19:0] b,
                        input logic cin, input int hold);
    int lat, exp_lat;
    bit ok;
    exp_lat = (op == 13) ? 21 : (op == 14 && b[3:0] != 0) ? b[3:0] + 1 : 1;
    accept(op, a, b, cin, ok);
    if (!ok) return;
    chk_en = 1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 4'd1;
      chk("req_ready_low_in_done", req_ready, 0);
      @(negedge clk);
      chk("rsp_valid_held", rsp_valid, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk_en = 0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
    chk("busy_after_hs", busy, 0);
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_result", rsp_result, 0);
    chk("reset_cout", rsp_cout, 0);
    chk("reset_zero", rsp_zero, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 1);
    rst = 1'b0;

    // Hand-computed expectations that pin the model.
    chk("lit_add", model(6, 20'hFFFFF, 20'h00001, 0), {1'b1, 1'b1, 20'h00000});
    chk("lit_sub", model(7, 20'h00005, 20'h00007, 0), {1'b1, 1'b0, 20'hFFFFE});
    chk("lit_mul1", model(13, 20'h00003, 20'h00005, 0), {1'b0, 1'b0, 20'h0000F});
    chk("lit_mul2", model(13, 20'h80000, 20'h00002, 0), {1'b1, 1'b1, 20'h00000});
    chk("lit_roln4", model(14, 20'h80001, 20'h00004, 0), {1'b0, 1'b0, 20'h00018});
    chk("lit_roln0", model(14, 20'h80001, 20'h00010, 0), {1'b0, 1'b0, 20'h80001});
    chk("lit_cmp", model(15, 20'h00007, 20'h00007, 0), {1'b0, 1'b1, 20'h00000});

    // Test-plan vectors.
    run_op(6,  20'hFFFFF, 20'h00001, 0, 0);
    run_op(7,  20'h00005, 20'h00007, 0, 0);
    run_op(13, 20'h00003, 20'h00005, 0, 5);
    run_op(13, 20'h80000, 20'h00002, 0, 0);
    run_op(14, 20'h80001, 20'h00004, 0, 0);
    run_op(14, 20'h80001, 20'h00010, 0, 0);

    // One vector per opcode plus edge cases.
    run_op(0,  20'h12345, 20'h00000, 0, 0);
    run_op(1,  20'h00000, 20'hABCDE, 0, 0);
    run_op(2,  20'hFFFFF, 20'h00000, 0, 0);
    run_op(3,  20'hF0F0F, 20'h0FFF0, 0, 0);
    run_op(4,  20'hF0F00, 20'h0F00F, 0, 2);
    run_op(5,  20'hA5A5A, 20'hA5A5A, 0, 0);
    run_op(6,  20'h12345, 20'h54321, 1, 0);
    run_op(7,  20'h00007, 20'h00005, 0, 0);
    run_op(8,  20'hFFFFF, 20'h00000, 0, 0);
    run_op(8,  20'h0FFFF, 20'h00000, 0, 0);
    run_op(9,  20'h00001, 20'hFFF13, 0, 0);
    run_op(9,  20'h80001, 20'h0000F, 0, 0);
    run_op(10, 20'h80000, 20'h0000F, 0, 0);
    run_op(11, 20'h80001, 20'h00000, 0, 0);
    run_op(12, 20'h00001, 20'h00000, 0, 0);
    run_op(13, 20'hFFFFF, 20'hFFFFF, 0, 0);
    run_op(13, 20'h00ABC, 20'h00123, 0, 0);
    run_op(14, 20'h12345, 20'h0000F, 0, 0);
    run_op(15, 20'h00005, 20'h00007, 0, 0);
    run_op(15, 20'h00007, 20'h00007, 0, 0);
    run_op(15, 20'h00009, 20'h00007, 0, 0);

    // Reset in the middle of a MUL aborts it.
    run_op(0, 20'h5A5A5, 20'h00000, 0, 0);
    accept(13, 20'hABCDE, 20'h12345, 0, ok);
    if (ok) begin
      repeat (10) @(negedge clk);
      chk("busy_in_exec", busy, 1);
      chk("no_rsp_in_exec", rsp_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_result", rsp_result, 0);
      chk("abort_cout", rsp_cout, 0);
      chk("abort_zero", rsp_zero, 0);
      chk("abort_busy", busy, 0);
      chk("abort_req_ready", req_ready, 1);
      repeat (25) begin
        @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 0);
      end
    end
    chk("lit_add_small", model(6, 20'h00002, 20'h00003, 0), {1'b0, 1'b0, 20'h00005});
    run_op(6, 20'h00002, 20'h00003, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
